sram_dp_be: RTL and testbench

//  Parametrised simple-dual-port SRAM: one write port with byte enables, one read port.

---
 rtl/sram_dp_be_pkg.sv | 21 ++
 rtl/sram_dp_be_clear_ctrl.sv | 98 +++++++++
 rtl/sram_dp_be.sv | 134 +++++++++++++
 tb/tb_sram_dp_be.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_dp_be_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the sram_dp_be simple-dual-port memory:
//   BYTE_W        width of one byte lane
//   sram_state_t  clear-controller states (CLEAR after reset, READY afterwards)
//   parity8()     even parity of one byte lane (1 when the lane has odd ones)
// -----------------------------------------------------------------------------
package sram_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } sram_state_t;

    function automatic logic parity8(input logic [BYTE_W-1:0] byte_val);
        return ^byte_val;
    endfunction

endpackage

// File: rtl/sram_dp_be_clear_ctrl.sv
// -----------------------------------------------------------------------------
// sram_clear_ctrl
// Post-reset clear sequencer and write-port arbiter for sram_dp_be.
// After reset it walks every word from address 0 to DEPTH-1 writing zero, one
// word per cycle, then hands the array write port to the user write request.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   wr_en, wr_addr, wr_be,      user write request (ignored while busy,
//   wr_data                       dropped when wr_addr >= DEPTH)
//   mem_we, mem_addr, mem_be,   write port driven into the array
//   mem_data
//   busy                        clear in progress
// -----------------------------------------------------------------------------
module sram_clear_ctrl
    import sram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int BE_W   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BE_W-1:0]   wr_be,
    input  logic [DATA_W-1:0] wr_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BE_W-1:0]   mem_be,
    output logic [DATA_W-1:0] mem_data,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);

    sram_state_t       state;
    sram_state_t       state_next;
    logic [ADDR_W-1:0] clr_ptr;
    logic [ADDR_W-1:0] clr_ptr_next;
    logic              wr_in_range;

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_X);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_next;
            clr_ptr <= clr_ptr_next;
        end
    end

    // Next-state logic: the last word is written in the same cycle the
    // FSM leaves CLEAR, so busy spans exactly DEPTH cycles.
    always_comb begin
        state_next   = state;
        clr_ptr_next = clr_ptr;
        case (state)
            CLEAR: begin
                if (clr_ptr == LAST_ADDR) begin
                    state_next   = READY;
                    clr_ptr_next = '0;
                end else begin
                    clr_ptr_next = clr_ptr + ADDR_W'(1);
                end
            end
            READY:   state_next = READY;
            default: state_next = CLEAR;
        endcase
    end

    // Output logic: write-port mux between clear walker and user port
    always_comb begin
        busy     = 1'b0;
        mem_we   = 1'b0;
        mem_addr = wr_addr;
        mem_be   = wr_be;
        mem_data = wr_data;
        case (state)
            CLEAR: begin
                busy     = 1'b1;
                mem_we   = 1'b1;
                mem_addr = clr_ptr;
                mem_be   = '1;
                mem_data = '0;
            end
            READY: begin
                mem_we = wr_en && !reset && wr_in_range && (|wr_be);
            end
            default: busy = 1'b1;
        endcase
    end

endmodule

// File: rtl/sram_dp_be.sv
// -----------------------------------------------------------------------------
// sram_dp_be
// Simple-dual-port SRAM with per-byte write enables and a registered read port
// (1-cycle latency, rd_valid strobe). After reset the array is zeroed one word
// per cycle; busy is high during that time and all requests are ignored.
// Same-address read and write on one edge returns the old word (read-first).
// Optional build macro SRAM_PARITY_EN: stores one even-parity bit per byte and
// flags rd_parity_err when a read word's stored parity disagrees with its data.
// Without it no parity storage exists and rd_parity_err is constant 0.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   wr_en, wr_addr,       write request, byte enables (bit b = bits 8b+7:8b)
//   wr_be, wr_data
//   rd_en, rd_addr        read request
//   rd_data, rd_valid     registered read data and its valid strobe
//   busy                  post-reset clear in progress
//   rd_parity_err         parity mismatch on the word in rd_data
// -----------------------------------------------------------------------------
module sram_dp_be
    import sram_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 256,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int BE_W   = DATA_W / BYTE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BE_W-1:0]   wr_be,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              rd_parity_err
);

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_data;
    logic              rd_fire;
    logic              rd_in_range;

    sram_clear_ctrl #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .BE_W   (BE_W)
    ) u_clear_ctrl (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_be    (wr_be),
        .wr_data  (wr_data),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_be   (mem_be),
        .mem_data (mem_data),
        .busy     (busy)
    );

    assign rd_fire     = rd_en && !busy;
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_X);

    // Array write port with byte-lane enables
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (mem_be[b]) begin
                    mem[mem_addr][b*BYTE_W +: BYTE_W] <= mem_data[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Read register: data holds when no read is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (rd_fire) begin
            rd_valid <= 1'b1;
            rd_data  <= rd_in_range ? mem[rd_addr] : '0;
        end else begin
            rd_valid <= 1'b0;
        end
    end

`ifdef SRAM_PARITY_EN
    function automatic logic [BE_W-1:0] word_parity(input logic [DATA_W-1:0] word);
        logic [BE_W-1:0] p;
        for (int b = 0; b < BE_W; b++) begin
            p[b] = parity8(word[b*BYTE_W +: BYTE_W]);
        end
        return p;
    endfunction

    logic [BE_W-1:0] par_mem [DEPTH];
    logic [BE_W-1:0] wr_par;

    // Clear writes zero data, whose parity is zero, so no special case is needed
    assign wr_par = word_parity(mem_data);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (mem_be[b]) begin
                    par_mem[mem_addr][b] <= wr_par[b];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_parity_err <= 1'b0;
        end else if (rd_fire) begin
            rd_parity_err <= rd_in_range ? (|(par_mem[rd_addr] ^ word_parity(mem[rd_addr]))) : 1'b0;
        end
    end
`else
    assign rd_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_dp_be.sv
// -----------------------------------------------------------------------------
// tb_sram_dp_be
// Bench for sram_dp_be. Two instances share clk/reset:
//   dut_a  DATA_W=8,  DEPTH=256  (clear timing, read-first, ignore-while-busy)
//   dut_b  DATA_W=32, DEPTH=200  (byte enables, out-of-range, random traffic)
// With SRAM_PARITY_EN defined, a corrupted word in dut_a is expected to raise
// rd_parity_err.
// -----------------------------------------------------------------------------
module tb_sram_dp_be;

    logic clk;
    logic reset;

    logic       a_wr_en, a_rd_en, a_rd_valid, a_busy, a_rd_parity_err;
    logic [7:0] a_wr_addr, a_rd_addr, a_wr_data, a_rd_data;
    logic [0:0] a_wr_be;

    logic        b_wr_en, b_rd_en, b_rd_valid, b_busy, b_rd_parity_err;
    logic [7:0]  b_wr_addr, b_rd_addr;
    logic [3:0]  b_wr_be;
    logic [31:0] b_wr_data, b_rd_data;

    int checks   = 0;
    int failures = 0;

    sram_dp_be #(.DATA_W(8), .DEPTH(256)) dut_a (
        .clk(clk), .reset(reset),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_be(a_wr_be), .wr_data(a_wr_data),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr),
        .rd_data(a_rd_data), .rd_valid(a_rd_valid), .busy(a_busy),
        .rd_parity_err(a_rd_parity_err)
    );

    sram_dp_be #(.DATA_W(32), .DEPTH(200)) dut_b (
        .clk(clk), .reset(reset),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_be(b_wr_be), .wr_data(b_wr_data),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .busy(b_busy),
        .rd_parity_err(b_rd_parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [7:0]  wa;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        re;
        logic [7:0]  ra;
        logic        ev;
        logic [31:0] ed;
    } vec_t;

    localparam int NV = 13;
    vec_t tbl [NV];

    logic [31:0] model [200];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        a_wr_en = 0; a_wr_addr = 0; a_wr_be = 1; a_wr_data = 0; a_rd_en = 0; a_rd_addr = 0;
        b_wr_en = 0; b_wr_addr = 0; b_wr_be = 0; b_wr_data = 0; b_rd_en = 0; b_rd_addr = 0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Counts busy cycles of both instances until both are idle.
    task automatic wait_clear(input bit poke, input int exp_a, input int exp_b, input string nm);
        int  ca   = 0;
        int  cb   = 0;
        int  n    = 0;
        bit  badv = 0;
        while ((a_busy || b_busy) && n < 2000) begin
            if (a_busy) ca++;
            if (b_busy) cb++;
            if (a_rd_valid || b_rd_valid) badv = 1;
            if (poke && a_busy) begin
                a_wr_en = 1; a_wr_addr = 8'd3; a_wr_data = 8'hFF;
                a_rd_en = 1; a_rd_addr = 8'd3;
            end else begin
                a_wr_en = 0; a_rd_en = 0;
            end
            @(posedge clk); #1;
            n++;
        end
        a_wr_en = 0; a_rd_en = 0;
        check({nm, "_timeout"}, (n < 2000), 1);
        check({nm, "_busy_a"}, ca, exp_a);
        check({nm, "_busy_b"}, cb, exp_b);
        check({nm, "_valid_while_busy"}, badv, 0);
        check({nm, "_valid_after_busy"}, a_rd_valid, 0);
    endtask

    task automatic a_cycle(input logic we, input logic [7:0] wa, input logic [7:0] wd,
                           input logic re, input logic [7:0] ra);
        a_wr_en = we; a_wr_addr = wa; a_wr_data = wd; a_wr_be = 1;
        a_rd_en = re; a_rd_addr = ra;
        @(posedge clk); #1;
        a_wr_en = 0; a_rd_en = 0;
    endtask

    task automatic a_read(input logic [7:0] ra, input logic [7:0] exp, input logic exp_err, input string nm);
        a_cycle(0, 0, 0, 1, ra);
        check({nm, "_valid"}, a_rd_valid, 1);
        check({nm, "_data"}, a_rd_data, exp);
        check({nm, "_perr"}, a_rd_parity_err, exp_err);
    endtask

    initial begin
        logic [31:0] exp_data;
        logic        exp_valid;
        logic [31:0] mask;
        logic        we, re;
        logic [7:0]  wa, ra;
        logic [3:0]  be;
        logic [31:0] wd;

        idle_inputs();

        // Reset state after two reset cycles
        do_reset(2);
        check("reset_busy_a", a_busy, 1);
        check("reset_busy_b", b_busy, 1);
        check("reset_valid_a", a_rd_valid, 0);
        check("reset_data_a", a_rd_data, 0);
        check("reset_data_b", b_rd_data, 0);
        check("reset_perr_a", a_rd_parity_err, 0);

        // Clear timing while poking write/read @3 on dut_a
        wait_clear(1, 256, 200, "clear1");

        // Write during clear was ignored; reads return zero one cycle later
        a_read(8'd3, 8'h00, 0, "rd3_after_clear");
        a_read(8'h00, 8'h00, 0, "rd00");
        a_read(8'hFF, 8'h00, 0, "rdFF");

        // Read-first on the same address, and hold of rd_data without rd_en
        a_cycle(1, 8'd7, 8'hAA, 0, 0);
        a_cycle(1, 8'd7, 8'h55, 1, 8'd7);
        check("rf_old_valid", a_rd_valid, 1);
        check("rf_old_data", a_rd_data, 8'hAA);
        a_cycle(0, 0, 0, 0, 0);
        check("hold_valid", a_rd_valid, 0);
        check("hold_data", a_rd_data, 8'hAA);
        a_read(8'd7, 8'h55, 0, "rf_new");

        // Reset pulse partway through a clear restarts it
        do_reset(1);
        repeat (100) @(posedge clk);
        #1;
        check("midclear_busy", a_busy, 1);
        do_reset(1);
        wait_clear(0, 256, 200, "clear2");
        a_read(8'd7, 8'h00, 0, "rd7_cleared");

`ifdef SRAM_PARITY_EN
        dut_a.mem[9][0] = ~dut_a.mem[9][0];
        a_read(8'd9, 8'h01, 1, "perr_bad");
        a_read(8'd8, 8'h00, 0, "perr_clean");
`else
        a_read(8'd9, 8'h00, 0, "noparity");
`endif

        // Table-driven vectors on the 32-bit, DEPTH=200 instance
        tbl[0]  = '{1'b1, 8'd5,   4'b1111, 32'hDEADBEEF, 1'b0, 8'd0,   1'b0, 32'h0};
        tbl[1]  = '{1'b1, 8'd5,   4'b0101, 32'h11223344, 1'b1, 8'd5,   1'b1, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 8'd0,   4'b0000, 32'h0,        1'b1, 8'd5,   1'b1, 32'hDE22BE44};
        tbl[3]  = '{1'b1, 8'd210, 4'b1111, 32'hFFFFFFFF, 1'b1, 8'd210, 1'b1, 32'h0};
        tbl[4]  = '{1'b0, 8'd0,   4'b0000, 32'h0,        1'b1, 8'd210, 1'b1, 32'h0};
        tbl[5]  = '{1'b1, 8'd199, 4'b1111, 32'hA5A5A5A5, 1'b0, 8'd0,   1'b0, 32'h0};
        tbl[6]  = '{1'b0, 8'd0,   4'b0000, 32'h0,        1'b1, 8'd199, 1'b1, 32'hA5A5A5A5};
        tbl[7]  = '{1'b1, 8'd199, 4'b0000, 32'h0,        1'b1, 8'd0,   1'b1, 32'h0};
        tbl[8]  = '{1'b0, 8'd0,   4'b0000, 32'h0,        1'b1, 8'd199, 1'b1, 32'hA5A5A5A5};
        tbl[9]  = '{1'b1, 8'd100, 4'b1000, 32'hCAFEF00D, 1'b1, 8'd199, 1'b1, 32'hA5A5A5A5};
        tbl[10] = '{1'b0, 8'd0,   4'b0000, 32'h0,        1'b1, 8'd100, 1'b1, 32'hCA000000};
        tbl[11] = '{1'b0, 8'd0,   4'b0000, 32'h0,        1'b0, 8'd0,   1'b0, 32'hCA000000};
        tbl[12] = '{1'b1, 8'd255, 4'b1111, 32'h12345678, 1'b1, 8'd255, 1'b1, 32'h0};

        for (int i = 0; i < NV; i++) begin
            b_wr_en = tbl[i].we; b_wr_addr = tbl[i].wa; b_wr_be = tbl[i].be; b_wr_data = tbl[i].wd;
            b_rd_en = tbl[i].re; b_rd_addr = tbl[i].ra;
            @(posedge clk); #1;
            check($sformatf("tbl%0d_valid", i), b_rd_valid, tbl[i].ev);
            check($sformatf("tbl%0d_data", i), b_rd_data, tbl[i].ed);
            check($sformatf("tbl%0d_perr", i), b_rd_parity_err, 0);
        end
        idle_inputs();

        // Random traffic against a word-array model (array starts zeroed)
        do_reset(1);
        wait_clear(0, 256, 200, "clear3");
        for (int i = 0; i < 200; i++) model[i] = 32'h0;
        exp_data = 32'h0;
        for (int i = 0; i < 500; i++) begin
            we = ($urandom_range(0, 3) != 0);
            wa = 8'($urandom_range(0, 219));
            be = 4'($urandom);
            wd = $urandom;
            re = ($urandom_range(0, 3) != 0);
            ra = ($urandom_range(0, 3) == 0) ? wa : 8'($urandom_range(0, 219));

            // Expected read sees the array before this cycle's write
            exp_valid = re;
            if (re) exp_data = (ra < 200) ? model[ra] : 32'h0;
            if (we && wa < 200) begin
                mask = 32'h0;
                for (int b = 0; b < 4; b++) if (be[b]) mask = mask | (32'hFF << (8 * b));
                model[wa] = (model[wa] & ~mask) | (wd & mask);
            end

            b_wr_en = we; b_wr_addr = wa; b_wr_be = be; b_wr_data = wd;
            b_rd_en = re; b_rd_addr = ra;
            @(posedge clk); #1;
            check($sformatf("rnd%0d_valid", i), b_rd_valid, exp_valid);
            check($sformatf("rnd%0d_data", i), b_rd_data, exp_data);
            check($sformatf("rnd%0d_perr", i), b_rd_parity_err, 0);
        end
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
